// File: rtl/rr_mux_arb.sv
// rtl/rr_mux_arb.sv - N:1 registered mux with round-robin / fixed-priority arbitration
module rr_mux_arb #(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 8,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rr_en,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   gnt;
    logic              found;
    logic              load_en;
    logic              accept;
    logic [DATA_W-1:0] gnt_data;

    assign load_en = ~out_valid | out_ready;
    assign accept  = found & load_en;

    // Scan starts at ptr in round-robin mode and at channel 0 otherwise.
    always_comb begin
        int idx;
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = rr_en ? int'(ptr) + k : k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && in_valid[CH_W'(idx)]) begin
                found = 1'b1;
                gnt   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == CH_W'(i)) begin
                gnt_data    = in_data[i*DATA_W +: DATA_W];
                in_ready[i] = accept;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            out_valid <= found;
            if (found) begin
                out_data <= gnt_data;
                out_ch   <= gnt;
                if (rr_en) begin
                    ptr <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb/tb_rr_mux_arb.sv - scoreboard bench for rr_mux_arb
module tb_rr_mux_arb;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int CH_W   = 2;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     rr_en = 1'b0;
    logic [NUM_CH-1:0]        in_valid = '0;
    logic [NUM_CH*DATA_W-1:0] in_data = '0;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_ready = 1'b0;

    rr_mux_arb #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rr_en     (rr_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] data;
    } word_t;

    int          checks = 0;
    int          errors = 0;
    word_t       sb[$];
    int          seen[$];
    int          m_ptr = 0;
    bit          m_ov = 1'b0;
    logic [7:0]  last_d = '0;
    logic [1:0]  last_ch = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = rr_en ? (m_ptr + k) % NUM_CH : k;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check outputs against the model, update the model, advance to next negedge.
    task automatic cycle();
        int         g;
        bit         le;
        logic [3:0] exp_rdy;
        word_t      w;
        #1;
        g  = model_grant();
        le = !m_ov || out_ready;
        exp_rdy = (g >= 0 && le) ? 4'(1 << g) : 4'b0;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            check("out_data", 32'(out_data), 32'(sb[0].data));
            check("out_ch", 32'(out_ch), 32'(sb[0].ch));
            if (out_ready) begin
                w = sb.pop_front();
                seen.push_back(int'(w.ch));
                last_d  = w.data;
                last_ch = w.ch;
            end
        end else begin
            check("held_data", 32'(out_data), 32'(last_d));
            check("held_ch", 32'(out_ch), 32'(last_ch));
        end
        if (le) begin
            if (g >= 0) begin
                w.ch   = 2'(g);
                w.data = in_data[g*DATA_W +: DATA_W];
                sb.push_back(w);
                m_ov = 1'b1;
                if (rr_en) m_ptr = (g + 1) % NUM_CH;
            end else begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        int         g;
        logic [3:0] exp_rdy;
        rst_n = 1'b0;
        sb.delete();
        m_ptr   = 0;
        m_ov    = 1'b0;
        last_d  = '0;
        last_ch = '0;
        #1;
        g = model_grant();
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int ch3_seen;
        @(negedge clk);

        // Reset with every channel requesting, then round-robin rotation
        in_valid  = 4'hF;
        in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        rr_en     = 1'b1;
        out_ready = 1'b1;
        do_reset();
        seen.delete();
        repeat (7) cycle();
        check("rot_count", 32'(seen.size()), 32'd6);
        for (int i = 0; i < 6 && i < seen.size(); i++) begin
            check("rot_seq", 32'(seen[i]), 32'(i % 4));
        end

        // Grant ch3 (ptr wraps to 0), then only ch1/ch2 valid
        cycle();
        seen.delete();
        in_valid = 4'b0110;
        repeat (2) cycle();
        in_valid = 4'b0000;
        repeat (2) cycle();
        check("sparse_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("sparse_0", 32'(seen[0]), 32'd3);
            check("sparse_1", 32'(seen[1]), 32'd1);
            check("sparse_2", 32'(seen[2]), 32'd2);
        end

        // Fixed priority starves ch3; switching to round-robin lets it in
        seen.delete();
        rr_en    = 1'b0;
        in_valid = 4'b1010;
        repeat (5) cycle();
        rr_en = 1'b1;
        repeat (2) cycle();
        in_valid = 4'b0000;
        repeat (2) cycle();
        check("fp_count", 32'(seen.size()), 32'd7);
        if (seen.size() == 7) begin
            for (int i = 0; i < 5; i++) check("fp_starve", 32'(seen[i]), 32'd1);
            ch3_seen = (seen[5] == 3 || seen[6] == 3) ? 1 : 0;
            check("rr_toggle_ch3", 32'(ch3_seen), 32'd1);
        end

        // Backpressure: ch2 word A5 waits while the held word stalls
        in_data  = {8'h33, 8'hA5, 8'h11, 8'h5C};
        in_valid = 4'b0001;
        cycle();
        in_valid  = 4'b0100;
        out_ready = 1'b0;
        repeat (3) cycle();
        check("bp_hold_data", 32'(out_data), 32'h5C);
        out_ready = 1'b1;
        cycle();
        in_valid = 4'b0000;
        check("bp_load_data", 32'(out_data), 32'hA5);
        cycle();

        // Drain to empty: one ch0 word then nothing
        in_data  = {8'h33, 8'h22, 8'h11, 8'h3C};
        in_valid = 4'b0001;
        cycle();
        in_valid = 4'b0000;
        repeat (3) cycle();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data", 32'(out_data), 32'h3C);
        check("drain_ch", 32'(out_ch), 32'd0);

        // Random traffic, random backpressure and mode flips
        repeat (300) begin
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rr_en     = ($urandom_range(0, 4) != 0);
            cycle();
        end

        // Reset while a word is held
        in_valid  = 4'b1000;
        rr_en     = 1'b1;
        out_ready = 1'b0;
        cycle();
        cycle();
        in_valid = 4'hF;
        in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        do_reset();
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
